// File: rtl/demux_sequencer.sv
// Serialises an upstream bit stream onto a 1-to-8 demux. Enabled channels are served
// round-robin; each bit is held HOLD cycles on d and then followed by GAP cycles of zero.
module demux_sequencer #(
    parameter int HOLD = 2,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_mask,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       d,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_e;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
    localparam logic [3:0] GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit         HAS_GAP   = (GAP > 0);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] ptr_q, sel_q, nxt_ch, cand, hi_ch;
    logic [7:0] mask_q;
    logic       bit_q, run_q, accept, slot_end, found;

    assign accept     = in_valid & in_ready;
    assign {s0, s1, s2} = sel_q;

    // Release is taken on the first clock edge, so the first acceptance lands on the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 3'd7;
            sel_q  <= '0;
            mask_q <= '0;
            bit_q  <= 1'b0;
        end else if (accept) begin
            ptr_q  <= nxt_ch;
            sel_q  <= nxt_ch;
            mask_q <= en_mask;
            bit_q  <= in_bit;
        end
    end

    // Search ptr+1 .. ptr+8; the wrap back onto ptr lets a lone channel be served again.
    always_comb begin
        nxt_ch = ptr_q;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!found && en_mask[cand]) begin
                nxt_ch = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        hi_ch = '0;
        for (int i = 0; i < 8; i++)
            if (mask_q[i]) hi_ch = 3'(i);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = HAS_GAP ? ST_GAP : ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        d        = 1'b0;
        busy     = 1'b0;
        slot_end = 1'b0;
        unique case (state_q)
            ST_IDLE:  in_ready = run_q & (|en_mask);
            ST_DRIVE: begin
                d        = bit_q;
                busy     = 1'b1;
                slot_end = !HAS_GAP && (cnt_q == HOLD_LAST);
            end
            ST_GAP: begin
                busy     = 1'b1;
                slot_end = (cnt_q == GAP_LAST);
            end
            default: ;
        endcase
        frame_done = slot_end & (sel_q == hi_ch);
    end

endmodule

// File: doc/demux_sequencer.md
DEMUX_SEQUENCER -- requirements
Module: demux_sequencer

Interface
REQ-001 Parameter HOLD, default 2: cycles d is driven per slot; legal range 1..15.
REQ-002 Parameter GAP, default 1: cycles d is forced 0 after each slot; legal range 0..15.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port en_mask  input  8  channel enables, bit k enables channel k.
REQ-006 Port in_valid  input  1  upstream bit available.
REQ-007 Port in_bit  input  1  upstream data bit.
REQ-008 Port in_ready  output  1  block can accept a bit this cycle.
REQ-009 Port d  output  1  data bit for the downstream 1-to-8 demux.
REQ-010 Port s0  output  1  channel select, MSB.
REQ-011 Port s1  output  1  channel select, middle bit.
REQ-012 Port s2  output  1  channel select, LSB; channel index = {s0,s1,s2}.
REQ-013 Port busy  output  1  high whenever the state is not IDLE.
REQ-014 Port frame_done  output  1  one-cycle pulse at the end of the slot for the highest enabled channel.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE and GAP, with a 4-bit slot counter.
REQ-016 In IDLE: in_ready = (en_mask != 0), d = 0, and select holds its last value.
REQ-017 Handshake: a bit SHALL be accepted only on a rising edge where in_valid & in_ready = 1.
REQ-018 in_ready SHALL be 0 in DRIVE and GAP.
REQ-019 When in_valid is high and in_ready is low, no bit is consumed; upstream holds in_bit.
REQ-020 On acceptance, the block SHALL register in_bit, en_mask and the next channel, and SHALL enter DRIVE.
REQ-021 The next channel SHALL be the first set bit of en_mask, searching ptr+1, ptr+2, ... ptr+8 modulo 8.
REQ-022 That search includes ptr itself, so a single enabled channel is served repeatedly.
REQ-023 ptr SHALL update to the served channel on acceptance.
REQ-024 Latency, for a bit accepted at edge N:
  - cycles N+1..N+HOLD: d = bit and {s0,s1,s2} = channel (DRIVE);
  - cycles N+HOLD+1..N+HOLD+GAP: d = 0 with select held (GAP);
  - then IDLE, with in_ready high in cycle N+HOLD+GAP+1.
REQ-025 When GAP = 0, the GAP state SHALL be skipped and DRIVE SHALL return directly to IDLE.
REQ-026 Sustained throughput SHALL be one bit per HOLD+GAP+1 cycles.
REQ-027 The select outputs SHALL change only on the acceptance edge, when d transitions from 0; select never changes while d = 1.
REQ-028 frame_done SHALL pulse high for exactly one cycle, the last cycle of the slot, when the served channel is the highest set bit of the mask registered at acceptance.
  - The last cycle of the slot is the final GAP cycle, or the final DRIVE cycle when GAP = 0.
REQ-029 en_mask changes after acceptance SHALL NOT affect the slot in progress; the new mask applies at the next acceptance.
REQ-030 If en_mask = 0 in IDLE, the block SHALL stay in IDLE with in_ready = 0.
REQ-031 busy = 1 exactly in DRIVE and GAP.

Reset
REQ-032 When rst_n = 0, the block SHALL immediately and asynchronously force the following:
  - state = IDLE, slot counter = 0, ptr = 7;
  - {s0,s1,s2} = 000, d = 0;
  - busy = 0, frame_done = 0, in_ready = 0 while reset is asserted.
REQ-033 Release of rst_n SHALL be synchronised internally.
  - First acceptance is possible on the second rising edge after deassertion.
  - The first search after reset starts at channel 0.
REQ-034 Reset asserted mid-slot SHALL abort the slot: d drops to 0 at once, and the bit is lost.

Verification
REQ-035 HOLD=2, GAP=1, en_mask=FF, 8 bits 1,0,1,1,0,0,1,0 streamed back-to-back:
  - channels 0..7 are served in order, each with d held 2 cycles followed by 1 gap cycle;
  - in_ready is high every 4th cycle;
  - frame_done pulses once, after channel 7.
REQ-036 en_mask=8'b1010_0100, 4 bits of 1:
  - channel sequence is 2,5,7,2;
  - frame_done pulses after the channel 7 slot only.
REQ-037 en_mask=8'b0001_0000, 3 bits:
  - every slot uses select 100 and frame_done pulses after each slot;
  - then en_mask=0 -> in_ready stays 0 and busy stays 0 indefinitely.
REQ-038 GAP=0, HOLD=1, en_mask=FF, in_valid held high:
  - one bit per 2 cycles;
  - d never 1 in an IDLE cycle;
  - select changes only on acceptance edges.
REQ-039 Reset mid-operation, rst_n pulsed low during a channel 3 DRIVE cycle:
  - d = 0 and select = 000 within the same cycle, without waiting for a clock edge;
  - after release, the next bit goes to channel 0 (en_mask=FF).
REQ-040 en_mask changed FF->01 during a channel 4 slot:
  - the channel 4 slot completes unchanged;
  - the next acceptance serves channel 0.
